qspi_arbiter: RTL and testbench
===============================

QSPI_ARBITER -- requirements
Module: qspi_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: instr_req in 1 fetch request; instr_addr in 25; instr_len in 2 (bytes-1); instr_ack out 1 accept pulse; instr_data out 32; instr_valid out 1 completion pulse.
REQ-004 SHALL have ports: data_req in 1; data_we in 1; data_addr in 25; data_len in 2 (bytes-1); data_wdata in 32; data_ack out 1; data_rdata out 32; data_valid out 1; data_err out 1 (valid with data_valid).
REQ-005 SHALL have QSPI-controller ports: q_addr_in out 25; q_data_in out 8; q_start_read out 1; q_start_write out 1; q_stall_txn out 1; q_stop_txn out 1; q_data_out in 8; q_data_req in 1; q_data_ready in 1; q_busy in 1.
REQ-006 Address map SHALL be: 0x0000000-0x0FFFFFF flash, 0x1000000-0x1FFFFFF RAM; addr[24]=0 means flash.

Function
REQ-007 SHALL implement states IDLE, START, XFER, STOP.
REQ-008 IDLE: if no request pending, SHALL stay IDLE with all q_* strobes 0.
REQ-009 Arbitration SHALL be round-robin: both pending -> grant the port not granted last; one pending -> grant it; last_grant resets to instr (data wins first tie).
REQ-010 Grant SHALL pulse the port's ack for exactly 1 cycle, latch addr/len/we/wdata, clear byte counter, and go to START next cycle.
REQ-011 Data write with addr[24]=0 SHALL be acked, then data_valid=1 and data_err=1 on the following cycle, no q_start_*, data_rdata unchanged, return to IDLE.
REQ-012 START: SHALL hold q_start_read (read) or q_start_write (write) at 1 with q_addr_in = latched addr until q_busy=1, then go to XFER; a start held while controller blocks reselect SHALL simply persist.
REQ-013 q_data_in SHALL always equal wdata byte [8*cnt+7:8*cnt] (cnt = byte counter), little-endian.
REQ-014 XFER read: each q_data_ready pulse SHALL store q_data_out into byte cnt of the assembly register and increment cnt; on the pulse where cnt==len, go to STOP.
REQ-015 XFER write: each q_data_req pulse SHALL increment cnt; on the pulse where cnt==len, go to STOP.
REQ-016 STOP: SHALL assert q_stop_txn until q_busy=0, then pulse the granted port's valid for 1 cycle and return to IDLE.
REQ-017 On valid, read result SHALL be presented on the granted port's rdata/instr_data with unread upper bytes zero; value SHALL hold until that port's next completion.
REQ-018 Write completion SHALL pulse data_valid with data_err=0 and data_rdata unchanged.
REQ-019 q_stall_txn SHALL be constant 0.
REQ-020 New ack SHALL NOT be issued before the prior transaction's valid; earliest next ack is the cycle after valid.
REQ-021 Requests SHALL be level-sensitive; requester holds req and operands stable until ack; req dropped before ack is never served.
REQ-022 q_data_ready/q_data_req seen outside XFER SHALL be ignored.

Reset
REQ-023 While rst=1: state IDLE, all acks/valids/data_err 0, q_start_*/q_stop_txn 0, cnt 0, last_grant=instr, instr_data/data_rdata 0.
REQ-024 rst asserted mid-transaction SHALL abandon it without a valid pulse; the controller is reset by the same reset in the system.

Verification
REQ-025 Instr read addr 0x0000100 len 3, flash bytes 11 22 33 44 -> instr_ack 1 cycle, one q_start_read, q_stop_txn after 4th q_data_ready, instr_data=0x44332211, instr_valid once.
REQ-026 Both req in same cycle after reset -> data acked first; instr acked the cycle after data_valid; repeat both -> order alternates.
REQ-027 Data write 0x1000010 len 1 wdata 0x0000BEEF -> q_start_write, q_data_in=EF then BE after first q_data_req, stop after 2nd q_data_req, data_valid=1 data_err=0.
REQ-028 Data write to 0x0000020 -> data_ack, next cycle data_valid=1 data_err=1, no q_start_* ever asserted.
REQ-029 Data read len 0 to 0x1800000 with q_busy delayed 3 cycles -> q_start_read held 3 cycles, data_rdata=0x000000XX with XX the read byte.
REQ-030 rst pulsed during XFER -> next cycle all outputs at REQ-023 values, no valid pulse, next request served normally.

Source files
------------

// File: rtl/qspi_arbiter.sv
// Round-robin arbiter that shares one QSPI controller between an instruction fetch port
// and a data load/store port. Addresses with addr[24]=0 are flash and cannot be written.
module qspi_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [24:0] instr_addr,
  input  logic [1:0]  instr_len,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [24:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_err,
  output logic [24:0] q_addr_in,
  output logic [7:0]  q_data_in,
  output logic        q_start_read,
  output logic        q_start_write,
  output logic        q_stall_txn,
  output logic        q_stop_txn,
  input  logic [7:0]  q_data_out,
  input  logic        q_data_req,
  input  logic        q_data_ready,
  input  logic        q_busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a requester holds req and operands steady until its one-cycle ack.
  // Completion is a one-cycle valid on the granted port; read data holds until that
  // port's next completion. Only one transaction is ever open, and no new ack is
  // issued before the open transaction's valid pulse.
  typedef enum logic [2:0] {IDLE, START, XFER, STOP, WERR} state_t;

  state_t      state, state_d;
  logic        last_data;
  logic        cur_data;
  logic        cur_we;
  logic [24:0] cur_addr;
  logic [1:0]  cur_len;
  logic [31:0] cur_wdata;
  logic [1:0]  cnt;
  logic [31:0] asm_q;

  logic grant_i, grant_d, stb, done;

  always_comb begin
    state_d = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    stb     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        // Data wins when alone or when instr was served last.
        if (data_req && (!instr_req || !last_data)) begin
          grant_d = 1'b1;
          state_d = (data_we && !data_addr[24]) ? WERR : START;
        end else if (instr_req) begin
          grant_i = 1'b1;
          state_d = START;
        end
      end
      START: if (q_busy) state_d = XFER;
      XFER: begin
        stb = cur_we ? q_data_req : q_data_ready;
        if (stb && cnt == cur_len) state_d = STOP;
      end
      STOP: begin
        if (!q_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_data   <= 1'b0;
      cur_data    <= 1'b0;
      cur_we      <= 1'b0;
      cur_addr    <= '0;
      cur_len     <= '0;
      cur_wdata   <= '0;
      cnt         <= '0;
      asm_q       <= '0;
      instr_ack   <= 1'b0;
      data_ack    <= 1'b0;
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      data_err    <= 1'b0;
      instr_data  <= '0;
      data_rdata  <= '0;
    end else begin
      state       <= state_d;
      instr_ack   <= grant_i;
      data_ack    <= grant_d;
      instr_valid <= done && !cur_data;
      data_valid  <= done && cur_data;
      data_err    <= (state == WERR);
      if (grant_i || grant_d) begin
        last_data <= grant_d;
        cur_data  <= grant_d;
        cur_we    <= grant_d && data_we;
        cur_addr  <= grant_d ? data_addr : instr_addr;
        cur_len   <= grant_d ? data_len : instr_len;
        cur_wdata <= data_wdata;
        cnt       <= '0;
        asm_q     <= '0;
      end
      if (stb) begin
        cnt <= cnt + 2'd1;
        if (!cur_we) asm_q[{cnt, 3'b000} +: 8] <= q_data_out;
      end
      // Write completions leave both read registers untouched.
      if (done && !cur_we) begin
        if (cur_data) data_rdata <= asm_q;
        else          instr_data <= asm_q;
      end
    end
  end

  assign q_start_read  = (state == START) && !cur_we && !rst;
  assign q_start_write = (state == START) && cur_we && !rst;
  assign q_stop_txn    = (state == STOP) && !rst;
  assign q_stall_txn   = 1'b0;
  assign q_addr_in     = cur_addr;
  assign q_data_in     = cur_wdata[{cnt, 3'b000} +: 8];
  assign dbg_state     = state;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Bench for qspi_arbiter: a behavioural QSPI controller with a byte memory, directed
// scenarios followed by randomized request mixes checked against a transaction-level model.
module tb_qspi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic [24:0] instr_addr = '0;
  logic [1:0]  instr_len = '0;
  logic        instr_ack, instr_valid;
  logic [31:0] instr_data;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [24:0] data_addr = '0;
  logic [1:0]  data_len = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack, data_valid, data_err;
  logic [31:0] data_rdata;
  logic [24:0] q_addr_in;
  logic [7:0]  q_data_in;
  logic        q_start_read, q_start_write, q_stall_txn, q_stop_txn;
  logic [7:0]  q_data_out = '0;
  logic        q_data_req = 1'b0;
  logic        q_data_ready = 1'b0;
  logic        q_busy = 1'b0;
  logic [2:0]  dbg_state;

  qspi_arbiter dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_len(instr_len),
    .instr_ack(instr_ack), .instr_data(instr_data), .instr_valid(instr_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_len(data_len),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .data_valid(data_valid), .data_err(data_err),
    .q_addr_in(q_addr_in), .q_data_in(q_data_in), .q_start_read(q_start_read),
    .q_start_write(q_start_write), .q_stall_txn(q_stall_txn), .q_stop_txn(q_stop_txn),
    .q_data_out(q_data_out), .q_data_req(q_data_req), .q_data_ready(q_data_ready),
    .q_busy(q_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- memory + controller model ----------------
  logic [7:0] mem [int];
  logic [7:0] wr_cap [$];
  int busy_dly = 0;
  int c_phase = 0;
  int c_delay = 0;
  int c_idx = 0;
  int c_addr = 0;
  bit c_rd = 1'b0;

  function automatic logic [7:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5a);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      q_data_ready = 1'b0;
      q_data_req   = 1'b0;
      if (rst) begin
        c_phase = 0;
        q_busy  = 1'b0;
      end else begin
        case (c_phase)
          0: begin
            if (q_start_read || q_start_write) begin
              c_rd   = q_start_read;
              c_addr = int'(q_addr_in);
              c_idx  = 0;
              if (busy_dly <= 1) begin
                q_busy  = 1'b1;
                c_phase = 2;
                c_delay = $urandom_range(0, 2);
              end else begin
                c_delay = busy_dly - 1;
                c_phase = 1;
              end
            end else if ($urandom_range(0, 3) == 0) begin
              q_data_out   = 8'($urandom);
              q_data_ready = 1'b1;
              q_data_req   = 1'b1;
            end
          end
          1: begin
            c_delay--;
            if (c_delay <= 0) begin
              q_busy  = 1'b1;
              c_phase = 2;
              c_delay = $urandom_range(0, 2);
            end
            // Stray strobes while the arbiter is still waiting for busy.
            if ($urandom_range(0, 1) == 0) begin
              q_data_out   = 8'($urandom);
              q_data_ready = 1'b1;
              q_data_req   = 1'b1;
            end
          end
          2: begin
            if (q_stop_txn) begin
              c_phase = 3;
              c_delay = $urandom_range(0, 2);
            end else if (c_delay > 0) begin
              c_delay--;
            end else begin
              if (c_rd) begin
                q_data_out   = mem_rd(c_addr + c_idx);
                q_data_ready = 1'b1;
              end else begin
                wr_cap.push_back(q_data_in);
                q_data_req = 1'b1;
              end
              c_idx++;
              c_delay = $urandom_range(0, 2);
            end
          end
          default: begin
            if (c_delay > 0) c_delay--;
            else begin
              q_busy  = 1'b0;
              c_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] exp_q [$];
  bit          last_data_m = 1'b0;
  logic [31:0] lr_instr = '0;
  logic [31:0] lr_data = '0;
  int          t_port, t_len, t_hold, ack_cyc;
  logic [24:0] t_addr;
  bit          t_we, t_err;
  int          st_rd, st_wr, stop_rise;
  bit          prev_stop;

  task automatic take_grant(input int port);
    logic [31:0] e;
    t_port = port;
    if (port == 0) begin
      t_addr = instr_addr; t_len = int'(instr_len); t_we = 1'b0; e = '0;
      instr_req  = 1'b0;
      instr_addr = 25'($urandom);
      instr_len  = 2'($urandom);
    end else begin
      t_addr = data_addr; t_len = int'(data_len); t_we = data_we; e = data_wdata;
      data_req   = 1'b0;
      data_addr  = 25'($urandom);
      data_len   = 2'($urandom);
      data_we    = 1'($urandom);
      data_wdata = $urandom;
    end
    t_err  = t_we && !t_addr[24];
    t_hold = (busy_dly <= 1) ? 1 : busy_dly;
    if (!t_we) begin
      e = '0;
      for (int k = 0; k <= t_len; k++) e = e | (32'(mem_rd(int'(t_addr) + k)) << (8 * k));
    end
    exp_q.push_back(e);
    last_data_m = (port == 1);
    st_rd = 0; st_wr = 0; stop_rise = 0; prev_stop = 1'b0;
    ack_cyc = cyc;
    wr_cap.delete();
  endtask

  task automatic finish_txn(input int port);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
    if (!t_we) begin
      chk("read_value", port == 1 ? data_rdata : instr_data, e);
      if (port == 1) lr_data = e; else lr_instr = e;
    end else begin
      chk("wr_rdata_kept", data_rdata, lr_data);
      chk("wr_byte_count", 32'(wr_cap.size()), t_err ? 0 : t_len + 1);
      for (int k = 0; k < wr_cap.size() && k <= t_len; k++) chk("wr_byte", 32'(wr_cap[k]), 32'(e[8*k +: 8]));
      if (!t_err) for (int k = 0; k <= t_len; k++) mem[int'(t_addr) + k] = e[8*k +: 8];
    end
    chk("other_port_held", port == 1 ? instr_data : data_rdata, port == 1 ? lr_instr : lr_data);
    chk("data_err", 32'(data_err), 32'(t_err));
    chk("start_read_cycles", st_rd, t_we ? 0 : t_hold);
    chk("start_write_cycles", st_wr, (t_we && !t_err) ? t_hold : 0);
    chk("stop_count", stop_rise, t_err ? 0 : 1);
    if (t_err) chk("err_latency", cyc - ack_cyc, 1);
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input bit ri, input bit rd);
    int first, remaining, budget, n_acks, outstanding, valid_cyc, port;
    bit both;
    both = ri && rd;
    if (both) first = last_data_m ? 0 : 1;
    else      first = rd ? 1 : 0;
    remaining = int'(ri) + int'(rd);
    budget = 0; n_acks = 0; outstanding = -1; valid_cyc = 0;
    instr_req = ri;
    data_req  = rd;
    while (remaining > 0 && budget < 400) begin
      step();
      budget++;
      if (instr_ack || data_ack) begin
        port = data_ack ? 1 : 0;
        chk("ack_overlap", 32'(instr_ack & data_ack), 0);
        chk("ack_while_open", 32'(outstanding >= 0), 0);
        chk("grant_order", port, (n_acks == 0) ? first : 1 - first);
        if (n_acks == 1 && both) chk("ack_after_valid", cyc - valid_cyc, 1);
        n_acks++;
        outstanding = port;
        take_grant(port);
      end
      if (q_start_read)  st_rd++;
      if (q_start_write) st_wr++;
      if (q_stop_txn && !prev_stop) stop_rise++;
      prev_stop = q_stop_txn;
      if (instr_valid || data_valid) begin
        port = data_valid ? 1 : 0;
        chk("valid_overlap", 32'(instr_valid & data_valid), 0);
        chk("valid_port", port, outstanding);
        finish_txn(port);
        outstanding = -1;
        remaining--;
        valid_cyc = cyc;
      end
    end
    chk("txn_timeout", remaining, 0);
    instr_req = 1'b0;
    data_req  = 1'b0;
    step();
    chk("quiet_after", 32'({instr_ack, data_ack, instr_valid, data_valid,
                            q_start_read, q_start_write, q_stop_txn, q_stall_txn}), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 32'({instr_ack, data_ack, instr_valid, data_valid, data_err,
                  q_start_read, q_start_write, q_stop_txn, q_stall_txn}), 0);
    chk({tag, "_instr_data"}, instr_data, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
  endtask

  task automatic mid_reset();
    int budget, nv;
    data_we = 1'b0; data_addr = 25'h1000040; data_len = 2'd3; busy_dly = 0;
    data_req = 1'b1;
    budget = 0;
    while (!data_ack && budget < 50) begin step(); budget++; end
    chk("mr_ack", 32'(data_ack), 1);
    data_req = 1'b0;
    budget = 0;
    while (!(c_phase == 2 && c_idx >= 2) && budget < 100) begin step(); budget++; end
    chk("mr_reach_xfer", 32'(budget < 100), 1);
    rst = 1'b1;
    step();
    check_reset_outputs("mr_reset");
    step();
    rst = 1'b0;
    nv = 0;
    repeat (8) begin
      step();
      if (instr_valid || data_valid || instr_ack || data_ack) nv++;
    end
    chk("mr_no_valid", nv, 0);
    last_data_m = 1'b0; lr_instr = '0; lr_data = '0;
    exp_q.delete();
    wr_cap.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int sel;
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    instr_addr = 25'h0000100; instr_len = 2'd3; busy_dly = 1;
    run_txn(1'b1, 1'b0);
    chk("instr_fetch_value", instr_data, 32'h4433_2211);

    for (int r = 0; r < 2; r++) begin
      instr_addr = 25'($urandom_range(0, 32'h0ff_ffff));
      instr_len = 2'($urandom);
      data_we = 1'b0; data_addr = 25'($urandom); data_len = 2'($urandom);
      busy_dly = $urandom_range(0, 2);
      run_txn(1'b1, 1'b1);
    end

    data_we = 1'b1; data_addr = 25'h1000010; data_len = 2'd1; data_wdata = 32'h0000_beef;
    busy_dly = 0;
    run_txn(1'b0, 1'b1);
    chk("beef_byte0", 32'(mem[32'h1000010]), 32'hef);
    chk("beef_byte1", 32'(mem[32'h1000011]), 32'hbe);

    data_we = 1'b1; data_addr = 25'h0000020; data_len = 2'd2; data_wdata = 32'h1234_5678;
    run_txn(1'b0, 1'b1);

    data_we = 1'b0; data_addr = 25'h1800000; data_len = 2'd0; busy_dly = 3;
    run_txn(1'b0, 1'b1);
    chk("len0_upper_zero", data_rdata & 32'hffff_ff00, 0);

    mid_reset();
    instr_addr = 25'h0000200; instr_len = 2'd1;
    data_we = 1'b0; data_addr = 25'h1000300; data_len = 2'd2; busy_dly = 0;
    run_txn(1'b1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(1, 3);
      instr_addr = 25'($urandom); instr_len = 2'($urandom);
      data_we = 1'($urandom); data_addr = 25'($urandom);
      data_len = 2'($urandom); data_wdata = $urandom;
      busy_dly = $urandom_range(0, 3);
      run_txn(sel[0], sel[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
